pipe_reg: RTL and testbench
===========================

# pipe_reg

Parameterised elastic pipeline register: a chain of DEPTH data stages, each WIDTH bits wide, with a valid/ready handshake at both ends. It replaces bare flop chains wherever a datapath needs retiming, stall support and a defined reset value. A stalled downstream consumer causes upstream bubbles to collapse, and a synchronous flush discards in-flight data. Typical use is between the ingest and processing blocks of the lab datapath.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 2, number of register stages (>= 1); DEPTH = 0 is illegal and fails elaboration
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every stage data register on reset
- CNT_W, $clog2(DEPTH+1), width of `count` (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  upstream word valid
- in_ready  output  1  pipe accepts the word this cycle
- in_data  input  WIDTH  upstream word
- out_valid  output  1  stage DEPTH-1 holds a word
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  stage DEPTH-1 data register
- count  output  CNT_W  number of valid stages, 0..DEPTH

## Operation
- Stage k (k = 0..DEPTH-1) holds v[k] and d[k]. Stage 0 faces the input; stage DEPTH-1 drives out_valid/out_data directly with no output logic.
- Ready chain (combinational): r[DEPTH] = out_ready; r[k] = !v[k] | r[k+1]; in_ready = r[0].
- Source of stage k: in_valid/in_data for k = 0, otherwise v[k-1]/d[k-1].
- At each clock edge with r[k] = 1: v[k] <= source valid; d[k] <= source data only when source valid = 1. d[k] holds otherwise.
- At each clock edge with r[k] = 0: stage k holds.
- Transfers: input when in_valid & in_ready; output when out_valid & out_ready. Order is preserved. No word is lost or duplicated.
- Bubble collapse: an empty stage accepts from upstream even while downstream is stalled, so a stalled pipe fills to DEPTH words.
- count = number of set v[k]. It is registered, updated by +1 on input-only, -1 on output-only, and unchanged on both or neither.
- flush (rst = 0): at the edge, all v[k] <= 0 and count <= 0. d[k] is unchanged. An input presented in the flush cycle is dropped, even though in_ready may read 1. An output handshake in the flush cycle is still valid for the consumer.
- rst takes priority over flush and the handshake. At the edge: all v[k] <= 0, all d[k] <= RESET_VAL, count <= 0.

## Timing
- Reset values: out_valid = 0, out_data = RESET_VAL, count = 0. in_ready = 1 after reset, because the pipe is empty.
- Latency through an empty pipe: a word accepted in cycle n is on out_valid/out_data in cycle n+DEPTH.
- Throughput: 1 word/cycle sustained when out_ready = 1.
- in_ready depends combinationally on out_ready through up to DEPTH gates. in_valid must not depend on in_ready.
- Full pipe (count = DEPTH) with out_ready = 1: in_ready = 1. A simultaneous input and output keeps count = DEPTH.
- Full pipe with out_ready = 0: in_ready = 0 and all stages hold.
- Reset or flush mid-stream clears the pipe in one edge. The first input is accepted in the next cycle.
- out_data and count are flop outputs.

## Test plan
All scenarios use WIDTH = 8, DEPTH = 3, RESET_VAL = 8'hA5 unless stated.
- Reset for 2 cycles, then idle -> out_valid = 0, out_data = 8'hA5, count = 0, in_ready = 1.
- Stream 8'h01..8'h05 back-to-back from cycle 0 with out_ready = 1 -> 8'h01 appears in cycle 3, then one word per cycle in order. count reaches 3 and returns to 0 after the stream drains.
- Hold out_ready = 0 and offer 8'h10..8'h13 -> 8'h10..8'h12 are accepted, then in_ready = 0 with count = 3. Raise out_ready -> outputs are 8'h10..8'h13 in order, with no duplicates.
- Bubble collapse: with out_ready = 0, send 8'h20, wait 4 cycles, then send 8'h21 and 8'h22 -> all accepted and count = 3. Toggle out_ready 1,0,1 -> the out sequence is 8'h20, 8'h21, 8'h22.
- Assert flush for 1 cycle with count = 2 and in_valid = 1 carrying 8'h33 -> the next cycle has count = 0, out_valid = 0, and 8'h33 never appears. Re-run with rst instead -> out_data = 8'hA5.
- Repeat the stream test with DEPTH = 1 and WIDTH = 1 -> latency is 1 cycle, throughput is 1/cycle, and in_ready = !out_valid | out_ready.

Source files
------------

// File: rtl/pipe_reg.sv
// ----------------------------------------------------------------------------
// pipe_reg_chk
//   Assertion-only companion of pipe_reg. It observes the stage valid bits and
//   the handshake and flags any break of the elastic-pipe invariants. It has no
//   outputs and contributes no logic to the datapath.
//
// Ports
//   clk, rst, flush  : clock, synchronous reset and flush of the observed pipe
//   valid            : per-stage valid bits, bit DEPTH-1 is the output stage
//   in_ready         : observed input ready
//   out_valid        : observed output valid
//   out_ready        : downstream ready
//   out_data         : observed output data register
//   count            : observed occupancy counter
// ----------------------------------------------------------------------------
module pipe_reg_chk #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             rst,
    input logic             flush,
    input logic [DEPTH-1:0] valid,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data,
    input logic [CNT_W-1:0] count
);

    // The registered occupancy must always agree with the stage valid bits.
    a_count_matches_valid: assert property (
        @(posedge clk) disable iff (rst)
        int'(count) == $countones(valid)
    );

    // A presented but unaccepted word stays put, unchanged, until taken.
    a_output_holds_when_stalled: assert property (
        @(posedge clk)
        (!rst && !flush && out_valid && !out_ready) |=> (out_valid && $stable(out_data))
    );

    // A full pipe whose consumer is stalled cannot take another word.
    a_full_stalled_not_ready: assert property (
        @(posedge clk) disable iff (rst)
        (int'(count) == DEPTH && !out_ready) |-> !in_ready
    );

endmodule

// ----------------------------------------------------------------------------
// pipe_reg
//   Elastic pipeline register: DEPTH stages of WIDTH-bit data, each with its
//   own valid bit, and a valid/ready handshake at both ends. An empty stage
//   always accepts from the stage behind it, so bubbles collapse while the
//   consumer is stalled and a stalled pipe fills to DEPTH words. flush drops
//   every in-flight word in one edge; rst also reloads the data registers.
//
// Parameters
//   WIDTH     : data width in bits (>= 1)
//   DEPTH     : number of register stages (>= 1)
//   RESET_VAL : value loaded into every data register on reset
//   CNT_W     : width of count, derived from DEPTH (do not override)
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (priority over everything)
//   flush     : synchronous clear of all valid bits and of count
//   in_valid  : upstream word valid
//   in_ready  : pipe accepts the upstream word this cycle (combinational)
//   in_data   : upstream word
//   out_valid : last stage holds a word (flop output)
//   out_ready : downstream accepts this cycle
//   out_data  : last stage data register (flop output)
//   count     : number of valid stages, 0..DEPTH (flop output)
// ----------------------------------------------------------------------------
module pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    // A zero-stage or zero-width pipe has no meaning; refuse to elaborate it.
    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
        $error("pipe_reg: DEPTH and WIDTH must both be at least 1");
    end

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r      [DEPTH];
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] src_valid_s;
    logic [WIDTH-1:0] src_data_s  [DEPTH];
    logic             in_fire_s;
    logic             out_fire_s;
    logic [CNT_W-1:0] count_r;

    // Stage k may load when it is empty or when every stage ahead of it can
    // move. Accumulating from the output end gives each stage the OR of
    // out_ready and all "empty" flags in front of it; this is the ready chain
    // written without a vector that feeds back on itself.
    always_comb begin
        logic acc;
        acc     = out_ready;
        ready_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc        = acc | ~valid_r[k];
            ready_s[k] = acc;
        end
    end

    // Stage 0 is fed from the input port, every later stage from its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_valid_s[k] = in_valid;
            assign src_data_s[k]  = in_data;
        end else begin : g_body
            assign src_valid_s[k] = valid_r[k-1];
            assign src_data_s[k]  = data_r[k-1];
        end
    end

    assign in_fire_s  = in_valid & ready_s[0];
    assign out_fire_s = valid_r[DEPTH-1] & out_ready;

    // Stage registers: a ready stage takes its source valid bit, but only
    // overwrites its data when the source actually carries a word, so the
    // data of an emptied stage keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k] <= RESET_VAL;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ready_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                    if (src_valid_s[k]) begin
                        data_r[k] <= src_data_s[k];
                    end
                end
            end
        end
    end

    // Occupancy counter: moves only on an input-only or output-only edge;
    // internal stage-to-stage moves never change the number of words held.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            case ({in_fire_s, out_fire_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign count     = count_r;

    pipe_reg_chk #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .valid     (valid_r),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count_r)
    );

endmodule

// File: tb/tb_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_reg
//   Bench for pipe_reg. Two instances share clock, reset and flush:
//   dut0 (WIDTH 8, DEPTH 3, RESET_VAL 8'hA5) and dut1 (WIDTH 1, DEPTH 1,
//   RESET_VAL 1'b1). A word-level model (a FIFO of words in flight plus the
//   slot each word occupies, words advancing one slot per cycle into free
//   space) predicts every output each cycle; directed scenarios add literal
//   expectations for latency, ordering, stall, bubble, flush and reset.
// ----------------------------------------------------------------------------
module tb_pipe_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;

    logic       iv0 = 1'b0;
    logic [7:0] id0 = 8'h00;
    logic       ordy0 = 1'b0;
    logic       ir0, ov0;
    logic [7:0] od0;
    logic [1:0] cnt0;

    logic       iv1 = 1'b0;
    logic       id1 = 1'b0;
    logic       ordy1 = 1'b1;
    logic       ir1, ov1, od1;
    logic [0:0] cnt1;

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .count(cnt0)
    );

    pipe_reg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .count(cnt1)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         mdep [2] = '{3, 1};
    bit         mv   [2][3];
    bit [7:0]   md   [2][3];
    bit [7:0]   q0 [$];
    bit [7:0]   q1 [$];

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit [7:0] qfront(input int m);
        if (m == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpop(input int m);
        if (m == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(input int m, input bit [7:0] v);
        if (m == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic qclear(input int m);
        if (m == 0) q0.delete();
        else        q1.delete();
    endtask

    // Advance the model by one clock edge given the inputs present at it.
    task automatic model_step(input int m, input bit rs, input bit fl,
                              input bit iv, input bit [7:0] idat, input bit ordy);
        int dp;
        bit ofire;
        dp = mdep[m];
        if (rs) begin
            for (int k = 0; k < 3; k++) mv[m][k] = 1'b0;
            qclear(m);
        end else begin
            ofire = mv[m][dp-1] && ordy;
            if (ofire) begin
                mv[m][dp-1] = 1'b0;
                qpop(m);
            end
            if (fl) begin
                for (int k = 0; k < 3; k++) mv[m][k] = 1'b0;
                qclear(m);
            end else begin
                for (int k = dp - 2; k >= 0; k--) begin
                    if (mv[m][k] && !mv[m][k+1]) begin
                        mv[m][k+1] = 1'b1;
                        md[m][k+1] = md[m][k];
                        mv[m][k]   = 1'b0;
                    end
                end
                if (iv && !mv[m][0]) begin
                    mv[m][0] = 1'b1;
                    md[m][0] = idat;
                    qpush(m, idat);
                end
            end
        end
    endtask

    task automatic check_inst(input int m, input logic ir, input logic ov,
                              input logic [7:0] od, input int cnt, input logic ordy);
        int dp;
        dp = mdep[m];
        chk($sformatf("d%0d_count", m), cnt, qsize(m));
        chk($sformatf("d%0d_in_ready", m), int'(ir), int'((qsize(m) < dp) || ordy));
        chk($sformatf("d%0d_out_valid", m), int'(ov), int'(mv[m][dp-1]));
        if (mv[m][dp-1]) begin
            chk($sformatf("d%0d_out_data", m), int'(od), int'(md[m][dp-1]));
            if (ordy && qsize(m) > 0)
                chk($sformatf("d%0d_order", m), int'(od), int'(qfront(m)));
        end
    endtask

    // Compare outputs against the model, then step the model over the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, ir0, ov0, od0, int'(cnt0), ordy0);
            check_inst(1, ir1, ov1, {7'b0, od1}, int'(cnt1), ordy1);
            chk("d1_ready_relation", int'(ir1), int'(!ov1 || ordy1));
        end
        model_step(0, rst, flush, iv0, id0, ordy0);
        model_step(1, rst, flush, iv1, {7'b0, id1}, ordy1);
    end

    // ---------------- stimulus ----------------
    logic       acc, of, of1, od1_s;
    logic [7:0] od;
    int         nout, first_c, maxc, w, fires, mode;
    logic [4:0] pat;
    logic [4:0] ordy_pat;

    task automatic cyc0(input logic v, input logic [7:0] d, input logic ordy,
                        input logic fl, input logic rs,
                        output logic acc_o, output logic of_o, output logic [7:0] od_o);
        @(posedge clk);
        #1;
        rst = rs; flush = fl;
        iv0 = v; id0 = d; ordy0 = ordy;
        iv1 = 1'b0; id1 = 1'b0; ordy1 = 1'b1;
        @(negedge clk);
        acc_o = v && ir0;
        of_o  = ov0 && ordy;
        od_o  = od0;
    endtask

    task automatic cyc1(input logic v, input logic d, input logic ordy,
                        output logic of_o, output logic od_o);
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        iv0 = 1'b0; id0 = 8'h00; ordy0 = 1'b1;
        iv1 = v; id1 = d; ordy1 = ordy;
        @(negedge clk);
        of_o = ov1 && ordy;
        od_o = od1;
    endtask

    initial begin
        // Reset for two cycles, then idle with the consumer stalled.
        cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc, of, od);
        chk_en = 1'b1;
        cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc, of, od);
        cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc, of, od);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_out_data", int'(od0), 8'hA5);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_in_ready", int'(ir0), 1);
        chk("rst_d1_out_data", int'(od1), 1);

        // Back-to-back stream 01..05 with the consumer always ready.
        nout = 0; first_c = -1; maxc = 0;
        for (int c = 0; c < 10; c++) begin
            cyc0(c < 5, 8'(c + 1), 1'b1, 1'b0, 1'b0, acc, of, od);
            if (c < 5) chk("stream_accept", int'(acc), 1);
            if (int'(cnt0) > maxc) maxc = int'(cnt0);
            if (of) begin
                if (first_c < 0) first_c = c;
                chk("stream_data", int'(od), nout + 1);
                chk("stream_cycle", c, 3 + nout);
                nout++;
            end
        end
        chk("stream_first_cycle", first_c, 3);
        chk("stream_words", nout, 5);
        chk("stream_max_count", maxc, 3);
        chk("stream_end_count", int'(cnt0), 0);

        // Stalled consumer: offer 10..13, only three fit.
        w = 0;
        for (int c = 0; c < 6; c++) begin
            cyc0(1'b1, 8'(8'h10 + w), 1'b0, 1'b0, 1'b0, acc, of, od);
            if (acc) w++;
        end
        chk("stall_accepted", w, 3);
        chk("stall_in_ready", int'(ir0), 0);
        chk("stall_count", int'(cnt0), 3);
        nout = 0;
        for (int c = 0; c < 10; c++) begin
            cyc0(w < 4, 8'(8'h10 + w), 1'b1, 1'b0, 1'b0, acc, of, od);
            if (acc) w++;
            if (of) begin
                chk("stall_out_data", int'(od), 8'h10 + nout);
                nout++;
            end
        end
        chk("stall_out_words", nout, 4);
        chk("stall_all_accepted", w, 4);

        // Bubble collapse: 20, four idle cycles, then 21 and 22, consumer stalled.
        cyc0(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, acc, of, od);
        chk("bubble_acc20", int'(acc), 1);
        for (int c = 0; c < 4; c++) cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc, of, od);
        cyc0(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, acc, of, od);
        chk("bubble_acc21", int'(acc), 1);
        cyc0(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc, of, od);
        chk("bubble_acc22", int'(acc), 1);
        cyc0(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc, of, od);
        chk("bubble_count", int'(cnt0), 3);
        ordy_pat = 5'b11101;
        nout = 0;
        for (int c = 0; c < 5; c++) begin
            cyc0(1'b0, 8'h00, ordy_pat[c], 1'b0, 1'b0, acc, of, od);
            if (of) begin
                chk("bubble_out_data", int'(od), 8'h20 + nout);
                nout++;
            end
        end
        chk("bubble_out_words", nout, 3);

        // Flush with two words held and 8'h33 offered in the flush cycle.
        cyc0(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, acc, of, od);
        cyc0(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, acc, of, od);
        cyc0(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, acc, of, od);
        chk("flush_pre_count", int'(cnt0), 2);
        cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc, of, od);
        chk("flush_count", int'(cnt0), 0);
        chk("flush_out_valid", int'(ov0), 0);
        fires = 0;
        for (int c = 0; c < 5; c++) begin
            cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc, of, od);
            if (of) fires++;
        end
        chk("flush_no_output", fires, 0);

        // Same scenario with rst in place of flush.
        cyc0(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, acc, of, od);
        cyc0(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, acc, of, od);
        cyc0(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, acc, of, od);
        cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc, of, od);
        chk("rst2_count", int'(cnt0), 0);
        chk("rst2_out_valid", int'(ov0), 0);
        chk("rst2_out_data", int'(od0), 8'hA5);
        fires = 0;
        for (int c = 0; c < 5; c++) begin
            cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc, of, od);
            if (of) fires++;
        end
        chk("rst2_no_output", fires, 0);

        // Randomised traffic on both instances, model checked every cycle.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c % 100 == 0) mode = int'($urandom_range(0, 2));
            rst   = ($urandom_range(0, 399) == 0);
            flush = ($urandom_range(0, 59) == 0);
            iv0   = ($urandom_range(0, 3) != 0);
            id0   = 8'($urandom);
            if (mode == 0)      ordy0 = 1'b1;
            else if (mode == 1) ordy0 = ($urandom_range(0, 1) == 1);
            else                ordy0 = ($urandom_range(0, 5) == 0);
            iv1   = ($urandom_range(0, 1) == 1);
            id1   = ($urandom_range(0, 1) == 1);
            ordy1 = ($urandom_range(0, 2) != 0);
        end

        // Single-stage, single-bit instance: stream, latency and full stall.
        cyc0(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc, of, od);
        cyc1(1'b0, 1'b0, 1'b1, of1, od1_s);
        chk("d1_rst_data", int'(od1_s), 1);
        pat  = 5'b01101;
        nout = 0;
        first_c = -1;
        for (int c = 0; c < 8; c++) begin
            cyc1(c < 5, pat[c % 5], 1'b1, of1, od1_s);
            if (of1) begin
                if (first_c < 0) first_c = c;
                chk("d1_stream_data", int'(od1_s), int'(pat[nout % 5]));
                chk("d1_stream_cycle", c, nout + 1);
                nout++;
            end
        end
        chk("d1_first_cycle", first_c, 1);
        chk("d1_stream_words", nout, 5);
        cyc1(1'b1, 1'b1, 1'b0, of1, od1_s);
        chk("d1_empty_ready", int'(ir1), 1);
        cyc1(1'b0, 1'b0, 1'b0, of1, od1_s);
        chk("d1_full_stalled_ready", int'(ir1), 0);
        chk("d1_full_count", int'(cnt1), 1);
        cyc1(1'b0, 1'b0, 1'b1, of1, od1_s);
        chk("d1_full_ready_passes", int'(ir1), 1);
        cyc1(1'b0, 1'b0, 1'b1, of1, od1_s);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
